srff_bank_arbiter: RTL and testbench

- Shares a bank of WIDTH SR flip-flop cells between NREQ requesters; each requester asks to set or reset one bit.
- Serialises requests with round-robin arbitration and drives one-hot s/r pulses into the bank.
- Guarantees s and r are never both high for the same bit, so the forbidden S=R=1 condition cannot occur.
- Checks the bank's q feedback after each pulse and reports completion and error per transaction.

---
 rtl/srff_pkg.sv | 6 +
 rtl/rr_arbiter.sv | 24 ++
 rtl/srff_bank_arbiter.sv | 76 +++++++
 tb/tb_srff_bank_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/srff_pkg.sv
// srff_pkg: shared FSM state type and operation encodings for the SR bank arbiter.
package srff_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, VERIFY} state_t;
  localparam logic OP_SET = 1'b1;
  localparam logic OP_RST = 1'b0;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin select, first requester at or above ptr with wrap-around.
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] gidx,
  output logic          hit
);
  always_comb begin
    hit = 1'b0;
    gidx = '0;
    // Scan from the farthest offset down so the nearest requester to ptr is the last one written.
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        hit = 1'b1;
        gidx = PW'((int'(ptr) + k) % N);
      end
    end
    grant = hit ? N'(1) << gidx : '0;
  end
endmodule

// File: rtl/srff_bank_arbiter.sv
// srff_bank_arbiter: serialises set/reset requests onto a shared SR bank with one-hot pulses
// and verifies the bank's q feedback after each pulse.
module srff_bank_arbiter
  import srff_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WIDTH = 8,
  parameter int PULSE_CYC = 2,
  localparam int IDXW = WIDTH > 1 ? $clog2(WIDTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      op,
  input  logic [NREQ*IDXW-1:0] idx,
  output logic [NREQ-1:0]      gnt,
  output logic                 done,
  output logic                 err,
  output logic [WIDTH-1:0]     s_out,
  output logic [WIDTH-1:0]     r_out,
  input  logic [WIDTH-1:0]     q_in
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int CW = PULSE_CYC > 1 ? $clog2(PULSE_CYC) : 1;
  state_t state, nstate;
  logic [PW-1:0] ptr, win, gidx;
  logic [NREQ-1:0] grant;
  logic hit, op_r, oor, oor_w;
  logic [IDXW-1:0] idx_r, idx_w;
  logic [CW-1:0] cnt;
  rr_arbiter #(.N(NREQ)) u_arb (
    .req(req),
    .ptr(ptr),
    .grant(grant),
    .gidx(gidx),
    .hit(hit)
  );
  assign idx_w = idx[int'(gidx)*IDXW +: IDXW];
  assign oor_w = int'(idx_w) >= WIDTH;
  always_ff @(posedge clk) state <= rst ? IDLE : nstate;
  always_comb begin
    nstate = state == IDLE  ? (hit ? (oor_w ? VERIFY : DRIVE) : IDLE)
           : state == DRIVE ? (cnt == '0 ? VERIFY : DRIVE)
           : IDLE;
    s_out = (state == DRIVE && op_r == OP_SET) ? WIDTH'(1) << idx_r : '0;
    r_out = (state == DRIVE && op_r != OP_SET) ? WIDTH'(1) << idx_r : '0;
    done = state == VERIFY;
    // oor short-circuits so an out-of-range idx_r never selects q_in.
    err = done && (oor || q_in[idx_r] != op_r);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt <= '0;
      ptr <= '0;
      win <= '0;
      op_r <= 1'b0;
      oor <= 1'b0;
      idx_r <= '0;
      cnt <= '0;
    end else begin
      if (state == IDLE && hit) begin
        gnt <= grant;
        win <= gidx;
        op_r <= op[gidx];
        idx_r <= idx_w;
        oor <= oor_w;
        cnt <= CW'(PULSE_CYC - 1);
      end
      if (state == DRIVE) cnt <= cnt - 1'b1;
      if (state == VERIFY) begin
        gnt <= '0;
        ptr <= win == PW'(NREQ - 1) ? '0 : win + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_srff_bank_arbiter.sv
// tb_srff_bank_arbiter: directed stimulus with a queued expectation scoreboard and an SR bank model.
module tb_srff_bank_arbiter;
  localparam int NREQ = 4;
  localparam int WIDTH = 6;
  localparam int PC = 2;
  localparam int IDXW = 3;
  typedef struct {
    logic [3:0] g;
    logic [5:0] s;
    logic [5:0] r;
    logic       e;
    int         pl;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] op = '0;
  logic [11:0] idx = '0;
  logic [3:0] gnt;
  logic done, err;
  logic [5:0] s_out, r_out, q_in;
  logic [5:0] bank = '0;
  logic [5:0] stuck = '0;
  exp_t sb[$];
  exp_t cur;
  int compared = 0;
  int mismatched = 0;
  int n_done = 0;
  int pcnt = 0;
  srff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .PULSE_CYC(PC)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .op(op),
    .idx(idx),
    .gnt(gnt),
    .done(done),
    .err(err),
    .s_out(s_out),
    .r_out(r_out),
    .q_in(q_in)
  );
  always #5 clk = ~clk;
  // Level-sensitive SR cells; a stuck mask models a cell whose q never rises.
  always @(s_out or r_out) bank <= (bank | s_out) & ~r_out;
  assign q_in = bank & ~stuck;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(int i, logic o, int ix);
    op[i] = o;
    idx[i*IDXW +: IDXW] = IDXW'(ix);
    req[i] = 1'b1;
  endtask
  task automatic expect_t(logic [3:0] g, logic [5:0] s, logic [5:0] r, logic e, int pl);
    sb.push_back('{g, s, r, e, pl});
  endtask
  task automatic wait_dones(int n);
    int t = 0;
    while (n_done < n && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (n_done < n) chk("timeout_done", n_done, n);
    tick();
  endtask
  always @(negedge clk) begin
    if (rst) pcnt = 0;
    else begin
      chk("invariant", {31'b0, ((s_out & r_out) == 0) && $countones(s_out | r_out) <= 1
          && $countones(gnt) <= 1 && (done || !err)}, 1);
      if ((s_out | r_out) != 0) begin
        if (sb.size() == 0) chk("pulse_unexpected", {s_out, r_out}, 0);
        else begin
          chk("pulse_sr", {s_out, r_out}, {sb[0].s, sb[0].r});
          chk("pulse_gnt", gnt, sb[0].g);
          pcnt++;
        end
      end
      if (done) begin
        if (sb.size() == 0) chk("done_unexpected", done, 0);
        else begin
          cur = sb.pop_front();
          chk("done_gnt", gnt, cur.g);
          chk("done_err", err, cur.e);
          chk("pulse_len", pcnt, cur.pl);
          n_done++;
        end
        pcnt = 0;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int t;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", {done, err}, 0);
    chk("rst_sr", {s_out, r_out}, 0);
    tick();
    rst = 1'b0;
    expect_t(4'b0001, 6'h08, 6'h00, 1'b0, 2);
    issue(0, 1'b1, 3);
    wait_dones(1);
    req[0] = 1'b0;
    chk("q3_set", q_in[3], 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) expect_t(4'(1 << k), 6'(1 << k), 6'h00, 1'b0, 2);
    expect_t(4'b0001, 6'h01, 6'h00, 1'b0, 2);
    for (int i = 0; i < 4; i++) issue(i, 1'b1, i);
    wait_dones(6);
    req = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_t(4'b0001, 6'h20, 6'h00, 1'b0, 2);
    expect_t(4'b0010, 6'h00, 6'h20, 1'b0, 2);
    issue(0, 1'b1, 5);
    issue(1, 1'b0, 5);
    wait_dones(7);
    req[0] = 1'b0;
    wait_dones(8);
    req[1] = 1'b0;
    chk("q5_conflict", q_in[5], 0);
    expect_t(4'b0100, 6'h00, 6'h00, 1'b1, 0);
    issue(2, 1'b1, 7);
    wait_dones(9);
    req[2] = 1'b0;
    expect_t(4'b1000, 6'h00, 6'h00, 1'b1, 0);
    issue(3, 1'b0, 6);
    wait_dones(10);
    req[3] = 1'b0;
    stuck = 6'b000100;
    expect_t(4'b0001, 6'h04, 6'h00, 1'b1, 2);
    issue(0, 1'b1, 2);
    wait_dones(11);
    req[0] = 1'b0;
    expect_t(4'b0010, 6'h00, 6'h08, 1'b0, 2);
    issue(1, 1'b0, 3);
    t = 0;
    while (!gnt[1] && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!gnt[1]) chk("timeout_gnt1", gnt, 4'b0010);
    #1;
    idx[IDXW +: IDXW] = 3'd4;
    op[1] = 1'b1;
    wait_dones(12);
    req[1] = 1'b0;
    stuck = '0;
    expect_t(4'b0100, 6'h02, 6'h00, 1'b0, 2);
    issue(2, 1'b1, 1);
    t = 0;
    while (!(gnt[2] && s_out != 0) && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!(gnt[2] && s_out != 0)) chk("timeout_pulse2", s_out, 6'h02);
    #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_gnt", gnt, 0);
    chk("midrst_sr", {s_out, r_out}, 0);
    chk("midrst_done", done, 0);
    issue(0, 1'b0, 2);
    tick();
    rst = 1'b0;
    expect_t(4'b0001, 6'h00, 6'h04, 1'b0, 2);
    expect_t(4'b0100, 6'h02, 6'h00, 1'b0, 2);
    wait_dones(13);
    req[0] = 1'b0;
    wait_dones(14);
    req[2] = 1'b0;
    repeat (4) tick();
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
